// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: commands are buffered in a small FIFO and folded, one per cycle,
// into a 4-bit accumulator; the end of each chain is reported on a valid/ready result port.
module alu_op_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter bit CLEAR_ON_LAST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [3:0]                    cmd_operand,
    input  logic                          cmd_last,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [3:0]                    res_data,
    output logic                          res_zero,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;
    localparam logic [2:0] OP_LOAD  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] operand;
        logic       last;
    } cmd_t;

    cmd_t             mem_q [FIFO_DEPTH];
    cmd_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    cmd_t             cmd_in, head;

    state_e           state_q, state_d;
    logic [3:0]       acc_q, acc_d;
    logic             res_valid_q, res_valid_d;
    logic [3:0]       res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;

    logic [3:0]       add_res, sub_res, and_res, xor_res, shift_res;
    logic [2:0]       mux_sel;
    logic [3:0]       mux_out, alu_res;

    // A full FIFO refuses input even if the head is popped this cycle (no pass-through).
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign cmd_ready  = !fifo_full && !rst;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == ST_EXEC) && !fifo_empty;
    assign cmd_in     = {cmd_op, cmd_operand, cmd_last};
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = cmd_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Shared datapath; LOAD takes the operand directly and bypasses the result mux.
    always_comb begin
        add_res = acc_q + head.operand;
        sub_res = acc_q - head.operand;
        and_res = acc_q & head.operand;
        xor_res = acc_q ^ head.operand;
        case (head.operand[1:0])
            2'b00:   shift_res = acc_q;
            2'b10:   shift_res = {1'b0, acc_q[3:1]};
            default: shift_res = {acc_q[2:0], 1'b0};
        endcase
        mux_sel = head.op;
        case (mux_sel)
            OP_ADD:   mux_out = add_res;
            OP_SUB:   mux_out = sub_res;
            OP_AND:   mux_out = and_res;
            OP_XOR:   mux_out = xor_res;
            OP_SHIFT: mux_out = shift_res;
            default:  mux_out = 4'h0;
        endcase
        alu_res = (head.op == OP_LOAD) ? head.operand : mux_out;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!fifo_empty) begin
                    acc_d = alu_res;
                    if (head.last) begin
                        state_d     = ST_RESULT;
                        res_valid_d = 1'b1;
                        res_data_d  = alu_res;
                        res_zero_d  = (alu_res == 4'h0);
                    end
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                    if (CLEAR_ON_LAST) begin
                        acc_d = 4'h0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= 4'h0;
            res_valid_q <= 1'b0;
            res_data_q  <= 4'h0;
            res_zero_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and level alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_zero   = res_zero_q;
    assign busy       = (state_q != ST_IDLE);
    assign fifo_level = level_q;

endmodule
